// File: rtl/io_seq_pkg.sv
// ---------------------------------------------------------------------------
// io_seq_pkg
// Shared definitions for the IO request sequencer slice.
//   - default read latency / response depth
//   - bit positions inside control_io ({write, byte})
//   - device-select field values carried in address bits [25:23]
//   - io_req_t: one CPU IO request as a packed bundle
//   - ctrlOf(): builds the 2-bit control word from a request
// No ports (package only).
// ---------------------------------------------------------------------------
package io_seq_pkg;

    localparam int READ_LATENCY_DEF = 2;
    localparam int RESP_DEPTH_DEF   = 4;

    localparam int CTRL_WRITE_BIT = 1;
    localparam int CTRL_BYTE_BIT  = 0;

    localparam int IO_SPACE_BIT = 31;
    localparam int DEV_SEL_HI   = 25;
    localparam int DEV_SEL_LO   = 23;

    typedef enum logic [2:0] {
        DEV_LED  = 3'd0,
        DEV_VRAM = 3'd1,
        DEV_SD   = 3'd2,
        DEV_PS2  = 3'd3
    } io_dev_e;

    // "byte" is a reserved word, so the byte-access flag is called isByte.
    typedef struct packed {
        logic        write;
        logic        isByte;
        logic [31:0] address;
        logic [15:0] data;
    } io_req_t;

    // Places the write/byte flags at their fixed control_io bit positions.
    function automatic logic [1:0] ctrlOf(input io_req_t r);
        logic [1:0] c;
        c                 = '0;
        c[CTRL_WRITE_BIT] = r.write;
        c[CTRL_BYTE_BIT]  = r.isByte;
        return c;
    endfunction

endpackage

// File: rtl/io_seq_resp_fifo.sv
// ---------------------------------------------------------------------------
// io_seq_resp_fifo
// In-order synchronous FIFO holding read responses until the consumer
// takes them. The head is read straight out of the storage registers, so
// it is stable while nothing is popped and a push into an empty FIFO shows
// up on head_o one cycle later (no bypass).
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (storage cleared to zero)
//   push_i      write pushData_i at the tail
//   pushData_i  entry to store
//   pop_i       drop the head entry
//   full_o      all DEPTH entries occupied
//   empty_o     no entries
//   head_o      oldest entry
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module io_seq_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];

    // Upstream credit accounting keeps pushes away from a full FIFO and
    // pops away from an empty one; the guards just make the storage safe
    // regardless.
    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    // Storage, pointers and occupancy. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    pushWhenFull: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o));

endmodule

// File: rtl/io_request_sequencer.sv
// ---------------------------------------------------------------------------
// io_request_sequencer
// Upstream stage of the memory-mapped IO block. Accepts CPU IO requests on
// a valid/ready handshake, drives the IO bus combinationally in the accept
// cycle, follows the fixed read latency of data_out_io and returns read
// data in order through a response FIFO. Reads are only accepted while a
// FIFO slot is reserved for them (credit scheme), so the FIFO cannot
// overflow.
// Ports:
//   main_clk, main_rst_n        clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_write, req_byte         access type
//   req_address, req_data       byte address (bit 31 = IO space), write data
//   resp_valid/resp_ready       response handshake
//   resp_data                   read data, in issue order
//   address_io, data_in_io      IO bus, driven only in an accept cycle
//   control_io                  {write, byte}, zero when idle
//   data_out_io                 IO read data, valid READ_LATENCY after issue
// Build option:
//   IO_SEQ_WRITE_ACK_EN  writes consume a credit and return a 16'h0000
//                        completion response through the FIFO.
// ---------------------------------------------------------------------------
module io_request_sequencer
    import io_seq_pkg::*;
#(
    parameter int READ_LATENCY = READ_LATENCY_DEF,
    parameter int RESP_DEPTH   = RESP_DEPTH_DEF
) (
    input  logic        main_clk,
    input  logic        main_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_address,
    input  logic [15:0] req_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic [31:0] address_io,
    output logic [15:0] data_in_io,
    output logic [1:0]  control_io,
    input  logic [15:0] data_out_io
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    io_req_t                 req;
    logic                    released_q;
    logic [CW-1:0]           credits_q;
    logic [CW-1:0]           credits_d;
    logic [READ_LATENCY-1:0] pipeValid_q;
    logic [READ_LATENCY-1:0] pipeValid_d;
    logic                    needsCredit;
    logic                    accept;
    logic                    tracked;
    logic                    push;
    logic                    pop;
    logic [15:0]             pushData;
    logic                    fifoFull;
    logic                    fifoEmpty;

    // Bundle the request pins so the bus drive uses the shared helpers.
    always_comb begin
        req         = '0;
        req.write   = req_write;
        req.isByte  = req_byte;
        req.address = req_address;
        req.data    = req_data;
    end

`ifdef IO_SEQ_WRITE_ACK_EN
    assign needsCredit = 1'b1;
`else
    assign needsCredit = !req_write;
`endif

    // A request that needs a response slot may only go when one is free.
    // released_q holds ready low until the first edge after reset release.
    assign req_ready = released_q && (!needsCredit || (credits_q != '0));
    assign accept    = req_valid && req_ready;
    assign tracked   = accept && needsCredit;

    // IO bus is driven only in the accept cycle; otherwise everything is
    // zero, which keeps address bit 31 clear so no IO access happens.
    always_comb begin
        address_io = '0;
        data_in_io = '0;
        control_io = '0;
        if (accept) begin
            address_io = req.address;
            data_in_io = req.data;
            control_io = ctrlOf(req);
        end
    end

    // Latency tracker: a token enters at issue and reaches the tail exactly
    // when data_out_io carries the answer for that request.
    always_comb begin
        pipeValid_d    = '0;
        pipeValid_d[0] = tracked;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeValid_d[i] = pipeValid_q[i-1];
        end
    end

    assign push = pipeValid_q[READ_LATENCY-1];
    assign pop  = resp_valid && resp_ready;

`ifdef IO_SEQ_WRITE_ACK_EN
    logic [READ_LATENCY-1:0] pipeWrite_q;
    logic [READ_LATENCY-1:0] pipeWrite_d;

    // Parallel flag pipe marking which tokens are write completions, so
    // they push zero instead of whatever the IO block presents.
    always_comb begin
        pipeWrite_d    = '0;
        pipeWrite_d[0] = accept && req_write;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipeWrite_d[i] = pipeWrite_q[i-1];
        end
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            pipeWrite_q <= '0;
        end else begin
            pipeWrite_q <= pipeWrite_d;
        end
    end

    assign pushData = pipeWrite_q[READ_LATENCY-1] ? 16'h0000 : data_out_io;
`else
    assign pushData = data_out_io;
`endif

    // Credits count free-and-unreserved FIFO slots: one is taken at issue
    // and returned when the consumer pops; both at once cancel out.
    always_comb begin
        credits_d = credits_q;
        case ({tracked, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    // State registers. Reset drops every in-flight token so nothing issued
    // before reset can ever produce a response afterwards.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            released_q  <= 1'b0;
            credits_q   <= CW'(RESP_DEPTH);
            pipeValid_q <= '0;
        end else begin
            released_q  <= 1'b1;
            credits_q   <= credits_d;
            pipeValid_q <= pipeValid_d;
        end
    end

    io_seq_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (16)
    ) u_respFifo (
        .clk_i      (main_clk),
        .rst_ni     (main_rst_n),
        .push_i     (push),
        .pushData_i (pushData),
        .pop_i      (pop),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .head_o     (resp_data)
    );

    assign resp_valid = !fifoEmpty;

    creditRange: assert property (@(posedge main_clk) disable iff (!main_rst_n)
        credits_q <= CW'(RESP_DEPTH));

    noPushWhenFull: assert property (@(posedge main_clk) disable iff (!main_rst_n)
        !(push && fifoFull));

endmodule
